rr_req_gnt_arbiter: RTL and testbench
=====================================

// Module: rr_req_gnt_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one req/gnt-protected resource between N requesters.
//   - Grants are registered and one-hot. An owner keeps gnt while it holds req.
//   - A hold limit forces release so no requester can hog the resource.
//   - Sits between requester blocks and the shared resource; pairs with the req/gnt SVA checkers.
//
// PARAMETERS
//   N         4   number of requesters (N >= 2)
//   MAX_HOLD  8   max consecutive gnt cycles per ownership (MAX_HOLD >= 1)
//
// PORTS
//   clk      in   1           single clock; all logic on posedge clk
//   rst_n    in   1           reset, synchronous, active-low
//   req      in   N           request vector; bit i = requester i
//   gnt      out  N           grant vector, one-hot or zero, registered
//   gnt_id   out  $clog2(N)   index of current owner; 0 when gnt == 0
//   busy     out  1           1 while any gnt bit is set (== |gnt)
//   timeout  out  1           1-cycle pulse: previous owner was force-released
//
// BEHAVIOUR
//   Reset (rst_n == 0 at posedge): state = IDLE, gnt = 0, gnt_id = 0, busy = 0, timeout = 0,
//     hold_cnt = 0, ptr = 0. Reset overrides everything, including mid-grant; no pulse is emitted.
//   Internal state
//     - ptr: round-robin pointer, $clog2(N) bits.
//     - hold_cnt: $clog2(MAX_HOLD+1) bits; counts gnt cycles of the current owner.
//   winner(v, p): first set bit of v scanning p, p+1, ..., N-1, 0, ..., p-1 (mod-N wrap).
//   FSM states
//     IDLE   gnt = 0
//       - posedge with req != 0: own = winner(req, ptr); gnt <= 1 << own; gnt_id <= own;
//         hold_cnt <= 1; ptr <= (own+1) % N; go to GRANT.
//       - Latency: req sampled at edge E gives gnt visible after E (1 cycle).
//     GRANT  gnt[own] = 1
//       - Release: posedge with req[own] == 0.
//       - Timeout: posedge with req[own] == 1 and hold_cnt == MAX_HOLD; timeout <= 1 for the next cycle.
//       - On release or timeout, let rem = req & ~(1 << own).
//         rem != 0: hand over with no gap. nw = winner(rem, ptr); gnt <= 1 << nw;
//                   gnt_id <= nw; hold_cnt <= 1; ptr <= (nw+1) % N; stay in GRANT.
//         rem == 0: gnt <= 0; gnt_id <= 0; hold_cnt <= 0; go to IDLE.
//       - Otherwise: hold_cnt <= hold_cnt + 1; gnt unchanged.
//   Timeout mask: the timed-out owner is excluded only from the arbitration at that edge.
//     It may win again one cycle later.
//   timeout is 0 in every cycle not immediately following a forced release.
//   Invariants
//     - $onehot0(gnt).
//     - gnt[i] rises only if req[i] was 1 at that edge.
//     - hold_cnt never exceeds MAX_HOLD.
//     - Simultaneous release plus a new request from the same index at the same edge is a release:
//       that index is excluded at that edge, like a timeout.
//
// TESTING  (N=4, MAX_HOLD=4; bench uses concurrent SVA, vacuous passes disabled)
//   1. Reset: rst_n=0 for 3 edges with req=4'b1111
//      -> gnt=0, gnt_id=0, busy=0, timeout=0 throughout.
//   2. Single requester: req=4'b0100 sampled at E0 -> gnt=4'b0100, gnt_id=2, busy=1 after E0;
//      req=0 before E3 -> gnt=0, busy=0 after E3.
//   3. Rotation: req=4'b1111 held, each owner drops req after 2 gnt cycles then re-raises
//      -> grant order 0,1,2,3,0 with no idle cycle between owners.
//   4. Timeout: req=4'b0010 held 12 cycles
//      -> gnt[1] high 4 cycles, then gnt=0 and timeout=1 for 1 cycle, then gnt[1] high again; repeats.
//   5. Timeout handover: req=4'b0011 held, owner 0
//      -> after 4 cycles gnt switches directly to 4'b0010 with timeout=1 that cycle.
//   6. Reset mid-grant: rst_n=0 at hold_cnt=2 with req=4'b1000
//      -> gnt=0 next cycle; after rst_n=1, requester 0 (ptr=0) wins over 3 when req=4'b1001.
//   SVA run on every test: onehot0(gnt); gnt[i] && !$past(gnt[i]) |-> $past(req[i]);
//     timeout |-> $past(busy); no gnt bit high more than MAX_HOLD consecutive cycles.

Source files
------------

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin req/gnt arbiter with registered one-hot grants.
// Owners keep gnt while holding req, up to MAX_HOLD cycles.
module rr_req_gnt_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]    state, state_n;
  logic [N-1:0]  gnt_n;
  logic [IW-1:0] id_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          to_n;

  logic [N-1:0]  arb;
  logic [IW-1:0] win;
  logic [IW-1:0] win_nxt;
  logic          rel;
  logic          force_rel;

  // First set bit of v scanning from p upward with wrap.
  function automatic logic [IW-1:0] winner(
    input logic [N-1:0]  v,
    input logic [IW-1:0] p
  );
    logic [IW-1:0] w;
    logic          hit;
    int            idx;
    w   = '0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(p) + k;
      if (idx >= N) idx = idx - N;
      if (!hit && v[idx]) begin
        w   = IW'(idx);
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  assign busy = |gnt;

  // The current owner is masked out, so a released or
  // timed-out owner cannot win again at the same edge.
  always_comb begin
    arb       = req & ~gnt;
    win       = winner(arb, ptr);
    win_nxt   = (win == IW'(N - 1)) ? '0 : win + IW'(1);
    rel       = (state == ST_GRANT) && !req[gnt_id];
    force_rel = (state == ST_GRANT) && req[gnt_id]
                && (hold_cnt == HW'(MAX_HOLD));
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    id_n    = gnt_id;
    hold_n  = hold_cnt;
    ptr_n   = ptr;
    to_n    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|arb) begin
          state_n    = ST_GRANT;
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
          id_n       = win;
          hold_n     = HW'(1);
          ptr_n      = win_nxt;
        end
      end
      ST_GRANT: begin
        if (rel || force_rel) begin
          to_n = force_rel;
          if (|arb) begin
            gnt_n      = '0;
            gnt_n[win] = 1'b1;
            id_n       = win;
            hold_n     = HW'(1);
            ptr_n      = win_nxt;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = '0;
            id_n    = '0;
            hold_n  = '0;
          end
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        id_n    = '0;
        hold_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      ptr      <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= id_n;
      hold_cnt <= hold_n;
      ptr      <= ptr_n;
      timeout  <= to_n;
    end
  end

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Bench for rr_req_gnt_arbiter: reference-model scoreboard
// with directed scenarios, random traffic and SVA.
module tb_rr_req_gnt_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  rr_req_gnt_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;

  // Reference model: owner index (-1 = none), cycles owned, pointer.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;
  bit m_to    = 0;

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic [3:0] rem;
    int w;
    if (!rst_n) begin
      m_owner = -1; m_hold = 0; m_ptr = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_hold = 1; m_ptr = (w + 1) % N;
      end
    end else begin
      bit rel, tmo;
      rel = !req[m_owner];
      tmo = !rel && (m_hold == MH);
      m_to = tmo;
      if (rel || tmo) begin
        rem = req;
        rem[m_owner] = 1'b0;
        w = pick(rem, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_hold = 1; m_ptr = (w + 1) % N;
        end else begin
          m_owner = -1; m_hold = 0;
        end
      end else begin
        m_hold++;
      end
    end
    e.g  = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    e.id = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e.to = m_to;
    exp_q.push_back(e);
    started = 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (gnt !== e.g || gnt_id !== e.id || timeout !== e.to
            || busy !== (e.g != 0)) begin
          errors++;
          $display("FAIL outputs t=%0t req=%b got gnt=%b id=%0d to=%b busy=%b want gnt=%b id=%0d to=%b busy=%b",
                   $time, req, gnt, gnt_id, timeout, busy,
                   e.g, e.id, e.to, (e.g != 0));
        end
      end
    end
  end

  // Protocol properties.
  a_onehot: assert property (@(posedge clk) $onehot0(gnt));
  a_to: assert property (@(posedge clk) disable iff (!rst_n)
    timeout |-> $past(busy));
  for (genvar i = 0; i < N; i++) begin : g_sva
    a_rise: assert property (@(posedge clk) disable iff (!rst_n)
      gnt[i] && !$past(gnt[i]) |-> $past(req[i]));
  end

  int run [N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      run[i] = gnt[i] ? run[i] + 1 : 0;
      a_hold: assert (run[i] <= MH)
        else $error("gnt[%0d] held %0d cycles", i, run[i]);
    end
  end

  task automatic drive(input logic [3:0] r, input logic rn, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      req   = r;
      rst_n = rn;
    end
  endtask

  initial begin
    logic [3:0] prev;
    int cnt;
    rst_n = 1'b0;
    req   = 4'b1111;
    // 1. reset with all requesting
    drive(4'b1111, 1'b0, 3);
    // 2. single requester
    drive(4'b0100, 1'b1, 3);
    drive(4'b0000, 1'b1, 2);
    // 3. rotation: each owner drops req after 2 grant cycles
    drive(4'b1111, 1'b1, 1);
    prev = '0; cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt != 0 && gnt == prev) cnt++;
      else cnt = 1;
      prev = gnt;
      req = (cnt >= 2) ? ~gnt : 4'b1111;
    end
    drive(4'b0000, 1'b1, 2);
    // 4. single requester hitting the hold limit
    drive(4'b0010, 1'b1, 12);
    drive(4'b0000, 1'b1, 2);
    // 5. timeout with handover
    drive(4'b0000, 1'b0, 1);
    drive(4'b0011, 1'b1, 12);
    drive(4'b0000, 1'b1, 2);
    // 6. reset mid-grant
    drive(4'b1000, 1'b1, 2);
    drive(4'b1000, 1'b0, 1);
    drive(4'b1001, 1'b1, 4);
    // random traffic with sticky requests and rare resets
    for (int k = 0; k < 600; k++) begin
      logic [3:0] r;
      r = req;
      for (int b = 0; b < N; b++)
        if ($urandom_range(5) == 0) r[b] = ~r[b];
      drive(r, ($urandom_range(49) != 0), 1);
    end
    drive(4'b0000, 1'b1, 3);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
